// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a CMD_W-bit command out MSB-first and, for read
// commands (top two bits 2'b11), clocks in an RD_W-bit reply MSB-first.
module spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CMD_W   = 10,
  parameter int unsigned RD_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CMD_W-1:0] tx_word,
  output logic             busy,
  output logic             done,
  output logic [RD_W-1:0]  rx_data,
  output logic             rx_valid,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SS_n
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned N_MAX = CMD_W + RD_W;
  localparam int unsigned CNT_W = $clog2(N_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] N_WR     = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] N_RD     = CNT_W'(N_MAX);
  localparam logic [CNT_W-1:0] RD_LEN   = CNT_W'(RD_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CMD_W-1:0] tx_shift;
  logic [RD_W-1:0]  rx_shift;
  logic             rd_flag;
  logic             div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // bit_cnt drops at each SCLK fall, so it reads 0 during the final low half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rd_flag  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= 1'b1;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          SS_n    <= 1'b1;
          SCLK    <= 1'b0;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
          div_cnt <= '0;
          if (start) begin
            tx_shift <= tx_word;
            rd_flag  <= (tx_word[CMD_W-1 -: 2] == 2'b11);
            bit_cnt  <= (tx_word[CMD_W-1 -: 2] == 2'b11) ? N_RD : N_WR;
            rx_shift <= '0;
            SS_n     <= 1'b0;
            MOSI     <= tx_word[CMD_W-1];
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (SCLK) begin
              SCLK     <= 1'b0;
              MOSI     <= tx_shift[CMD_W-2];
              tx_shift <= {tx_shift[CMD_W-2:0], 1'b0};
              bit_cnt  <= bit_cnt - CNT_W'(1);
            end else if (bit_cnt == '0) begin
              SS_n  <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
              if (rd_flag) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end else begin
              SCLK <= 1'b1;
              // only the last RD_W rises of a read frame carry reply bits
              if (rd_flag && (bit_cnt <= RD_LEN)) begin
                rx_shift <= {rx_shift[RD_W-2:0], MISO};
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_DIV=2 and 1) driven by
// directed and random frames, checked against a frame-level reference model.
module tb_spi_master;

  localparam int unsigned CMD_W = 10;
  localparam int unsigned RD_W  = 8;
  localparam int unsigned DIV0  = 2;
  localparam int unsigned DIV1  = 1;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] start_v;
  logic [1:0] sclk_v, mosi_v, ss_n_v, busy_v, done_v, rxv_v;
  logic [1:0] miso_v = '0;
  logic [CMD_W-1:0] tx_a [2];
  logic [RD_W-1:0]  rx_a [2];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(DIV0), .CMD_W(CMD_W), .RD_W(RD_W)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .tx_word(tx_a[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rx_data(rx_a[0]), .rx_valid(rxv_v[0]),
    .SCLK(sclk_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]), .SS_n(ss_n_v[0]));

  spi_master #(.CLK_DIV(DIV1), .CMD_W(CMD_W), .RD_W(RD_W)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .tx_word(tx_a[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rx_data(rx_a[1]), .rx_valid(rxv_v[1]),
    .SCLK(sclk_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]), .SS_n(ss_n_v[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? int'(DIV0) : int'(DIV1);
  endfunction

  // Pin monitor and bench slave, sampled on the falling clk edge
  int rises [2], ss_low [2], ss_high [2], gap [2], run [2];
  int half_err [2], done_cnt [2], rxv_cnt [2];
  logic [31:0]     mosi_bits [2];
  logic [RD_W-1:0] rep [2];
  logic [1:0]      sclk_q = '0;
  logic [1:0]      ss_q = 2'b11;
  int              pos;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ss_q[i] && !ss_n_v[i]) begin
        gap[i] = ss_high[i];
        ss_high[i] = 0;
        rises[i] = 0;
        mosi_bits[i] = '0;
        ss_low[i] = 0;
        half_err[i] = 0;
        done_cnt[i] = 0;
        rxv_cnt[i] = 0;
        miso_v[i] = 1'b0;
      end
      // every SCLK level (and the SETUP phase) inside a frame must last CLK_DIV cycles
      if (sclk_v[i] != sclk_q[i] || ss_n_v[i] != ss_q[i]) begin
        if (!ss_q[i] && run[i] != div_of(i)) half_err[i]++;
        run[i] = 1;
      end else begin
        run[i]++;
      end
      if (!ss_n_v[i]) ss_low[i]++;
      else ss_high[i]++;
      if (!sclk_q[i] && sclk_v[i] && !ss_n_v[i]) begin
        rises[i]++;
        mosi_bits[i] = {mosi_bits[i][30:0], mosi_v[i]};
      end
      if (sclk_q[i] && !sclk_v[i] && !ss_n_v[i]) begin
        pos = rises[i] + 1;
        miso_v[i] = (pos > int'(CMD_W) && pos <= int'(CMD_W + RD_W)) ?
                    rep[i][int'(CMD_W + RD_W) - pos] : 1'b0;
      end
      if (done_v[i]) done_cnt[i]++;
      if (rxv_v[i]) rxv_cnt[i]++;
      sclk_q[i] = sclk_v[i];
      ss_q[i] = ss_n_v[i];
    end
  end

  logic [RD_W-1:0] exp_rx [2];

  task automatic run_frame(input int i, input logic [CMD_W-1:0] w,
                           input logic [RD_W-1:0] r, input bit poke, input bit b2b);
    bit rd;
    bit seen;
    int n;
    logic [31:0] exp_bits;
    rd = (w[CMD_W-1 -: 2] == 2'b11);
    n = int'(CMD_W) + (rd ? int'(RD_W) : 0);
    exp_bits = 32'(w);
    if (rd) exp_bits = exp_bits << RD_W;
    rep[i] = r;
    tx_a[i] = w;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    check("ss_low_after_start", 32'(ss_n_v[i]), 32'd0);
    check("busy_after_start", 32'(busy_v[i]), 32'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      start_v[i] = 1'b1;
      tx_a[i] = ~w;
      @(negedge clk);
      start_v[i] = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done_v[i]) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (rd) exp_rx[i] = r;
    check("busy_in_done", 32'(busy_v[i]), 32'd1);
    check("ss_n_in_done", 32'(ss_n_v[i]), 32'd1);
    check("sclk_in_done", 32'(sclk_v[i]), 32'd0);
    check("rx_valid_in_done", 32'(rxv_v[i]), 32'(rd));
    check("rx_data", 32'(rx_a[i]), 32'(exp_rx[i]));
    @(negedge clk);
    check("done_one_cycle", 32'(done_v[i]), 32'd0);
    check("busy_cleared", 32'(busy_v[i]), 32'd0);
    check("rx_valid_one_cycle", 32'(rxv_v[i]), 32'd0);
    check("sclk_rises", 32'(rises[i]), 32'(n));
    check("mosi_bits", mosi_bits[i], exp_bits);
    check("ss_low_cycles", 32'(ss_low[i]), 32'(div_of(i) * (1 + 2 * n)));
    check("half_period_errs", 32'(half_err[i]), 32'd0);
    check("done_count", 32'(done_cnt[i]), 32'd1);
    check("rx_valid_count", 32'(rxv_cnt[i]), 32'(rd));
    if (b2b) check("ss_gap", 32'(gap[i]), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev_i;
    int ii;
    bit seen;
    logic [CMD_W-1:0] w;
    reset = 1'b1;
    start_v = '0;
    for (int i = 0; i < 2; i++) begin
      tx_a[i] = '0;
      rep[i] = '0;
      exp_rx[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_ss_n", 32'(ss_n_v), 32'd3);
    check("reset_sclk", 32'(sclk_v), 32'd0);
    check("reset_mosi", 32'(mosi_v), 32'd0);
    check("reset_busy", 32'(busy_v | done_v | rxv_v), 32'd0);
    check("reset_rx_data", 32'({rx_a[1], rx_a[0]}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 10'h0A5, 8'h5A, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(0, 10'h3C7, 8'hC3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(0, 10'h0A5, 8'hFF, 1'b1, 1'b0);
    run_frame(0, 10'h3C7, 8'h96, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    run_frame(1, 10'h3FF, 8'h00, 1'b0, 1'b0);
    run_frame(1, 10'h3D2, 8'hA7, 1'b0, 1'b1);

    // reset in the middle of a read frame
    repeat (2) @(negedge clk);
    rep[0] = 8'h77;
    tx_a[0] = 10'h3AB;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (rises[0] >= 3) seen = 1'b1;
    end
    check("reset_test_in_shift", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_ss_n", 32'(ss_n_v[0]), 32'd1);
    check("abort_sclk", 32'(sclk_v[0]), 32'd0);
    check("abort_mosi", 32'(mosi_v[0]), 32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_rx_data", 32'(rx_a[0]), 32'd0);
    exp_rx[0] = '0;
    exp_rx[1] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0]), 32'd0);
    check("abort_idle_ss_n", 32'(ss_n_v[0]), 32'd1);

    prev_i = -1;
    for (int k = 0; k < 20; k++) begin
      bit b2b;
      ii = int'($urandom_range(0, 1));
      w = CMD_W'($urandom);
      if ($urandom_range(0, 1) == 1) w[CMD_W-1 -: 2] = 2'b11;
      b2b = (ii == prev_i) && ($urandom_range(0, 2) == 0);
      if (!b2b) repeat ($urandom_range(1, 4)) @(negedge clk);
      run_frame(ii, w, RD_W'($urandom), ($urandom_range(0, 3) == 0), b2b);
      prev_i = ii;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master that drives the SPI slave in this codebase.
- Frame: a 10-bit command word is shifted out MSB-first on MOSI.
- When the command's top two bits are 2'b11 (read command), 8 more SCLK periods follow, and the slave's 8-bit reply is captured from MISO MSB-first.
- Sits between a host-side command interface (start/busy/done) and the four SPI pins.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255; SCLK frequency = clk / (2*CLK_DIV).
- CMD_W, 10, command frame width in bits (fixed at 10 for the current slave; must be ≥3).
- RD_W, 8, read-reply width in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- tx_word  in  CMD_W  command frame; latched on the start cycle.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses, inclusive.
- done  out  1  one-cycle pulse at end of frame.
- rx_data  out  RD_W  last read reply; holds its value until the next read completes.
- rx_valid  out  1  one-cycle pulse, coincident with done, on read frames only.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in.
- SS_n  out  1  active-low slave select.

Behaviour:
- Reset (async, any state): SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rx_valid=0, rx_data=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, SETUP, SHIFT, DONE. All outputs are registered.
- IDLE:
  - SS_n=1, SCLK=0, MOSI=0.
  - On start=1: latch tx_word into the shift register; set rd_flag = tx_word[CMD_W-1:CMD_W-2]==2'b11; load bit count N = CMD_W + (rd_flag ? RD_W : 0); go to SETUP.
- SETUP:
  - Lasts exactly CLK_DIV cycles.
  - SS_n=0, SCLK=0, MOSI=tx_word[CMD_W-1].
  - Then go to SHIFT with SCLK rising.
- SHIFT (N bit periods, each 2*CLK_DIV cycles):
  - High half: SCLK=1 for CLK_DIV cycles. On the cycle SCLK goes 0→1, sample MISO. Captures during the command phase are discarded; captures during the read phase shift into rx_shift LSB-in, so the reply is received MSB-first.
  - Low half: SCLK=0 for CLK_DIV cycles. On the 1→0 transition MOSI presents the next command bit. During the read phase, and after the last command bit, MOSI=0.
  - After the low half of bit N, go to DONE. The last low half doubles as the SS_n hold time.
- DONE (1 cycle):
  - SS_n=1, SCLK=0, done=1, busy=1.
  - If rd_flag: rx_data<=rx_shift and rx_valid=1.
  - Next state is IDLE.
- SS_n low duration per frame = CLK_DIV*(1+2N) cycles. SS_n is high for at least 2 cycles between frames (DONE + IDLE).
- Latency: start accepted in cycle t → SS_n low at t+1 → first SCLK rise at t+1+CLK_DIV.
- start while busy=1 is ignored, with no queuing.
- tx_word changes after the start cycle have no effect on the frame in progress.
- rx_data is not modified by write frames.
- A half-period counter wraps at CLK_DIV-1. The bit counter counts down from N and reaches 0 exactly at the final low half; there are no off-by-one extra edges.

Test Plan:
- Reset: assert reset mid-SHIFT → SS_n=1, SCLK=0, MOSI=0, busy=0 on the next sample point with no clk edge needed; no done pulse; rx_data=0.
- Write frame, CLK_DIV=2, tx_word=10'h0A5:
  - MOSI sampled at each SCLK rise = 0,0,1,0,1,0,0,1,0,1.
  - Exactly 10 SCLK rises; SS_n low 42 cycles.
  - done pulses once; rx_valid stays 0; rx_data unchanged.
- Read frame, CLK_DIV=2, tx_word=10'h3C7, bench slave drives 8'hC3 on MISO during bits 11-18:
  - 18 SCLK rises; SS_n low 74 cycles; MOSI=0 during the read phase.
  - rx_data=8'hC3 with rx_valid=1 in the done cycle.
- start re-pulsed during busy, plus a tx_word change mid-frame → ignored; the frame completes with the original bits; exactly one done pulse.
- Back-to-back: start asserted in the first IDLE cycle after done → accepted; SS_n high for exactly 2 cycles between frames.
- CLK_DIV=1, tx_word=10'h3FF, MISO=8'h00 → SCLK toggles every cycle; SS_n low 37 cycles; rx_data=8'h00 with rx_valid=1.
